// File: rtl/ef_gpio8_pkg.sv
// Shared constants for the ef_gpio8 Wishbone GPIO block: register offsets,
// RIS group layout, reset values and the address/byte-lane helpers.
package ef_gpio8_pkg;

  localparam logic [15:0] OffDatai = 16'h0000;
  localparam logic [15:0] OffDatao = 16'h0004;
  localparam logic [15:0] OffDir   = 16'h0008;
  localparam logic [15:0] OffIm    = 16'h0F00;
  localparam logic [15:0] OffMis   = 16'h0F04;
  localparam logic [15:0] OffRis   = 16'h0F08;
  localparam logic [15:0] OffIc    = 16'h0F0C;

  localparam int unsigned RisHighBase = 0;
  localparam int unsigned RisLowBase  = 8;
  localparam int unsigned RisRiseBase = 16;
  localparam int unsigned RisFallBase = 24;

  localparam logic [7:0]  DataoRst = 8'h00;
  localparam logic [7:0]  DirRst   = 8'h00;
  localparam logic [31:0] ImRst    = 32'h0;
  localparam logic [31:0] RisRst   = 32'h0;

  typedef enum logic [2:0] {
    RegDatai,
    RegDatao,
    RegDir,
    RegIm,
    RegMis,
    RegRis,
    RegIc,
    RegNone
  } reg_e;

  function automatic reg_e decode_reg(input logic [15:0] off);
    case (off)
      OffDatai: decode_reg = RegDatai;
      OffDatao: decode_reg = RegDatao;
      OffDir:   decode_reg = RegDir;
      OffIm:    decode_reg = RegIm;
      OffMis:   decode_reg = RegMis;
      OffRis:   decode_reg = RegRis;
      OffIc:    decode_reg = RegIc;
      default:  decode_reg = RegNone;
    endcase
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/ef_gpio8_sync.sv
// Pad input synchroniser, previous-value register and per-pin level/edge flags.
// EF_GPIO8_WB_SYNC_EN selects a 2-flop synchroniser; otherwise a single stage.
module ef_gpio8_sync
  import ef_gpio8_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  pin_i,
  output logic [7:0]  sync_o,
  output logic [31:0] flags_o
);

  logic [7:0] sync_d, sync_q;
  logic [7:0] prev_d, prev_q;

`ifdef EF_GPIO8_WB_SYNC_EN
  logic [7:0] meta_d, meta_q;

  always_comb begin
    meta_d = pin_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) meta_q <= 8'h00;
    else       meta_q <= meta_d;
  end
`else
  always_comb begin
    sync_d = pin_i;
  end
`endif

  always_comb begin
    prev_d = sync_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 8'h00;
      prev_q <= 8'h00;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // prev resets low, so a pin already high out of reset reports one rising edge.
  always_comb begin
    flags_o = 32'h0;
    flags_o[RisHighBase +: 8] = sync_q;
    flags_o[RisLowBase  +: 8] = ~sync_q;
    flags_o[RisRiseBase +: 8] = sync_q & ~prev_q;
    flags_o[RisFallBase +: 8] = ~sync_q & prev_q;
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/ef_gpio8_wb.sv
// 8-bit GPIO with Wishbone classic slave, direction/data registers and a
// 32-source level/edge interrupt unit. Build option: EF_GPIO8_WB_SYNC_EN.
module ef_gpio8_wb
  import ef_gpio8_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic        irq,
  input  logic [7:0]  io_in,
  output logic [7:0]  io_out,
  output logic [7:0]  io_oe
);

  logic [7:0]  datao_d, datao_q;
  logic [7:0]  dir_d, dir_q;
  logic [31:0] im_d, im_q;
  logic [31:0] ris_d, ris_q;
  logic [31:0] dat_o_d, dat_o_q;
  logic        ack_d, ack_q;
  logic        irq_d, irq_q;

  logic [7:0]  sync;
  logic [31:0] flags;
  logic        req, wr, rd;
  logic [31:0] wmask, rdata, ic_clr;
  reg_e        rsel;

  logic unused_adr;
  assign unused_adr = ^adr_i[31:16];

  ef_gpio8_sync u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pin_i   (io_in),
    .sync_o  (sync),
    .flags_o (flags)
  );

  always_comb begin
    req   = cyc_i & stb_i & ~ack_q;
    wr    = req & we_i;
    rd    = req & ~we_i;
    wmask = byte_mask(sel_i);
    rsel  = decode_reg(adr_i[15:0]);

    rdata = 32'h0;
    case (rsel)
      RegDatai: rdata = {24'h0, sync};
      RegDatao: rdata = {24'h0, datao_q};
      RegDir:   rdata = {24'h0, dir_q};
      RegIm:    rdata = im_q;
      RegMis:   rdata = ris_q & im_q;
      RegRis:   rdata = ris_q;
      default:  rdata = 32'h0;
    endcase

    datao_d = datao_q;
    dir_d   = dir_q;
    im_d    = im_q;
    ic_clr  = 32'h0;
    if (wr) begin
      case (rsel)
        RegDatao: datao_d = (datao_q & ~wmask[7:0]) | (dat_i[7:0] & wmask[7:0]);
        RegDir:   dir_d   = (dir_q & ~wmask[7:0]) | (dat_i[7:0] & wmask[7:0]);
        RegIm:    im_d    = (im_q & ~wmask) | (dat_i & wmask);
        RegIc:    ic_clr  = dat_i & wmask;
        default:  ;
      endcase
    end

    // Fresh flags win over a same-cycle clear, so persistent levels re-assert.
    ris_d   = (ris_q & ~ic_clr) | flags;
    irq_d   = |(ris_q & im_q);
    ack_d   = req;
    dat_o_d = rd ? rdata : dat_o_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      datao_q <= DataoRst;
      dir_q   <= DirRst;
      im_q    <= ImRst;
      ris_q   <= RisRst;
      dat_o_q <= 32'h0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      datao_q <= datao_d;
      dir_q   <= dir_d;
      im_q    <= im_d;
      ris_q   <= ris_d;
      dat_o_q <= dat_o_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
    end
  end

  assign dat_o  = dat_o_q;
  assign ack_o  = ack_q;
  assign irq    = irq_q;
  assign io_out = datao_q;
  assign io_oe  = dir_q;

endmodule

// File: tb/tb_ef_gpio8_wb.sv
// Self-checking bench for ef_gpio8_wb: bus register access, pad I/O,
// interrupt flags and reset behaviour, with read expectations queued.
module tb_ef_gpio8_wb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [3:0]  sel_i = '0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        we_i  = 1'b0;
  logic        ack_o;
  logic        irq;
  logic [7:0]  io_in = '0;
  logic [7:0]  io_out;
  logic [7:0]  io_oe;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] ADatai = 32'h0000;
  localparam logic [31:0] ADatao = 32'h0004;
  localparam logic [31:0] ADir   = 32'h0008;
  localparam logic [31:0] AIm    = 32'h0F00;
  localparam logic [31:0] AMis   = 32'h0F04;
  localparam logic [31:0] ARis   = 32'h0F08;
  localparam logic [31:0] AIc    = 32'h0F0C;

  always #5 clk_i = ~clk_i;

  ef_gpio8_wb dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .dat_o  (dat_o),
    .sel_i  (sel_i),
    .cyc_i  (cyc_i),
    .stb_i  (stb_i),
    .we_i   (we_i),
    .ack_o  (ack_o),
    .irq    (irq),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oe  (io_oe)
  );

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    bit got = 0;
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk_i); #1;
      if (ack_o) got = 1;
    end
    rd = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL bus_ack_timeout adr=%h: ack_o never seen, required within 10 cycles", adr);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, adr, dat, sel, unused_rd);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, rd);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    n_tests++;
    if ({ack_o, irq, io_out, io_oe, dat_o} !== 50'h0) begin
      n_fail++;
      $display("FAIL reset_state got ack=%b irq=%b out=%h oe=%h dat=%h, want all 0",
               ack_o, irq, io_out, io_oe, dat_o);
    end
    @(negedge clk_i); rst_i = 1'b0;
  endtask

  task automatic test_output();
    logic [31:0] rd, exp;
    wb_write(ADir, 32'hFF, 4'hF);
    wb_write(ADatao, 32'hA5, 4'hF);
    n_tests++;
    if (io_oe !== 8'hFF) begin n_fail++; $display("FAIL output_oe got %h want ff", io_oe); end
    n_tests++;
    if (io_out !== 8'hA5) begin n_fail++; $display("FAIL output_out got %h want a5", io_out); end
    exp_q.push_back(32'hA5);
    wb_read(ADatao, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL output_rd_datao got %h want %h", rd, exp); end
    exp_q.push_back(32'hFF);
    wb_read(ADir, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL output_rd_dir got %h want %h", rd, exp); end
  endtask

  task automatic test_input();
    logic [31:0] rd, exp;
    wb_write(ADir, 32'h00, 4'hF);
    io_in = 8'hAB;
    repeat (3) @(posedge clk_i);
    exp_q.push_back(32'h000000AB);
    wb_read(ADatai, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL input_datai got %h want %h", rd, exp); end
    // DIR must not gate readback
    wb_write(ADir, 32'hFF, 4'hF);
    io_in = 8'h3C;
    repeat (3) @(posedge clk_i);
    exp_q.push_back(32'h0000003C);
    wb_read(ADatai, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL input_datai_dirout got %h want %h", rd, exp); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd, exp;
    wb_write(ADatai, 32'hFFFF_FFFF, 4'hF);
    wb_write(32'h0010, 32'hFFFF_FFFF, 4'hF);
    exp_q.push_back(32'h0000003C);
    wb_read(ADatai, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL ro_write_datai got %h want %h", rd, exp); end
    exp_q.push_back(32'h0);
    wb_read(32'h0010, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL unmapped_read got %h want %h", rd, exp); end
    exp_q.push_back(32'h0);
    wb_read(AIc, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL ic_read got %h want %h", rd, exp); end
    exp_q.push_back(32'hA5);
    wb_read(32'h0001_0004, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL upper_adr_ignored got %h want %h", rd, exp); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd, exp;
    io_in = 8'h00;
    repeat (4) @(posedge clk_i);
    wb_write(AIc, 32'hFFFF_FFFF, 4'hF);
    wb_write(AIm, 32'h0001_0000, 4'hF);
    repeat (3) @(posedge clk_i); #1;
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_idle got %b want 0", irq); end
    io_in = 8'h01;
    repeat (4) @(posedge clk_i);
    exp_q.push_back(32'h0001_FF01);
    exp_q.push_back(32'h0001_0000);
    wb_read(ARis, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL edge_ris got %h want %h", rd, exp); end
    wb_read(AMis, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL edge_mis got %h want %h", rd, exp); end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq_set got %b want 1", irq); end
    wb_write(AIc, 32'h0001_0000, 4'hF);
    exp_q.push_back(32'h0000_FF01);
    wb_read(ARis, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL edge_ris_cleared got %h want %h", rd, exp); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_cleared got %b want 0", irq); end
  endtask

  task automatic test_level_irq();
    logic [31:0] rd, exp;
    io_in = 8'h00;
    repeat (4) @(posedge clk_i);
    wb_write(AIm, 32'h0000_0100, 4'hF);
    repeat (2) @(posedge clk_i); #1;
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL level_irq_set got %b want 1", irq); end
    wb_write(AIc, 32'h0000_0100, 4'hF);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL level_irq_hold[%0d] got %b want 1", i, irq); end
      @(posedge clk_i); #1;
    end
    exp_q.push_back(32'h0100_FF01);
    wb_read(ARis, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL level_ris got %h want %h", rd, exp); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd, exp;
    wb_write(ADatao, 32'hFF, 4'hF);
    wb_write(ADatao, 32'h00, 4'b0010);
    exp_q.push_back(32'hFF);
    wb_read(ADatao, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL byte_lane_datao got %h want %h", rd, exp); end
    n_tests++;
    if (io_out !== 8'hFF) begin n_fail++; $display("FAIL byte_lane_out got %h want ff", io_out); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp;
    wb_write(ADir, 32'hFF, 4'hF);
    wb_write(ADatao, 32'hA5, 4'hF);
    wb_write(AIm, 32'h1, 4'hF);
    io_in = 8'h01;
    repeat (3) @(posedge clk_i); #1;
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL rst_pre_irq got %b want 1", irq); end
    @(posedge clk_i); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = ADatao; dat_i = 32'h5A; sel_i = 4'hF;
    @(posedge clk_i); #1;
    n_tests++;
    if (ack_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack got %b want 1", ack_o); end
    #2 rst_i = 1'b1;
    #1;
    n_tests++;
    if ({ack_o, io_out, io_oe, irq} !== 18'h0) begin
      n_fail++;
      $display("FAIL rst_mid got ack=%b out=%h oe=%h irq=%b want all 0", ack_o, io_out, io_oe, irq);
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    wb_read(ADatao, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL rst_datao got %h want %h", rd, exp); end
    wb_read(ADir, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL rst_dir got %h want %h", rd, exp); end
    wb_read(AIm, rd); exp = exp_q.pop_front(); n_tests++;
    if (rd !== exp) begin n_fail++; $display("FAIL rst_im got %h want %h", rd, exp); end
  endtask

  initial begin
    test_reset();
    test_output();
    test_input();
    test_unmapped();
    test_edge_irq();
    test_level_irq();
    test_byte_lane();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
